// File: rtl/sync_counter_pkg.sv
// Shared limits and width helpers for the sync_counter_array slice.
package sync_counter_pkg;

  localparam int unsigned MAX_CHANNELS     = 32;
  localparam int unsigned MAX_COUNTER_BITS = 32;
  localparam int unsigned MAX_OFFSET_BITS  = 16;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned counter_width(input int unsigned counter_bits,
                                                input int unsigned offset_bits);
    return counter_bits + offset_bits;
  endfunction

endpackage

// File: rtl/sync_counter_channel.sv
// One prescaled counter with clear/load/increment priority, sticky overflow and snapshot.
// SYNC_COUNTER_SATURATE_EN: hold at all-ones instead of wrapping.
module sync_counter_channel
  import sync_counter_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = 32,
  parameter int unsigned OFFSET_BITS  = 0
) (
  input  logic                    tclk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    load,
  input  logic [COUNTER_BITS-1:0] load_value,
  input  logic                    snap,
  input  logic                    ovf_clr,
  output logic [COUNTER_BITS-1:0] snap_value,
  output logic                    ovf
);

  localparam int unsigned W = counter_width(COUNTER_BITS, OFFSET_BITS);

  logic [W-1:0] cnt;
  logic [W-1:0] snap_reg;
  logic [W-1:0] load_word;
  logic         at_max;
  logic         ovf_event;

  always_comb begin
    load_word = W'(load_value) << OFFSET_BITS;
    at_max    = &cnt;
    ovf_event = enable && !clear && !load && at_max;
  end

  always_ff @(posedge tclk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      snap_reg <= '0;
      ovf      <= 1'b0;
    end else begin
      if (snap)
        snap_reg <= cnt;
      if (clear)
        cnt <= '0;
      else if (load)
        cnt <= load_word;
      else if (enable) begin
`ifdef SYNC_COUNTER_SATURATE_EN
        if (!at_max)
          cnt <= cnt + W'(1);
`else
        cnt <= cnt + W'(1);
`endif
      end
      // A fresh overflow outranks a same-cycle clear request.
      if (ovf_event)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  assign snap_value = snap_reg[W-1:OFFSET_BITS];

endmodule

// File: rtl/sync_counter_array.sv
// N-channel tclk-domain counter array with snapshot, registered read mux and sticky overflow.
// SYNC_COUNTER_SATURATE_EN selects saturating counters inside each channel.
module sync_counter_array
  import sync_counter_pkg::*;
#(
  parameter  int unsigned NUM_CHANNELS = 2,
  parameter  int unsigned COUNTER_BITS = 32,
  parameter  int unsigned OFFSET_BITS  = 0,
  localparam int unsigned CH_W         = clog2_min1(NUM_CHANNELS)
) (
  input  logic                    tclk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic [NUM_CHANNELS-1:0] clear,
  input  logic                    load,
  input  logic [CH_W-1:0]         load_sel,
  input  logic [COUNTER_BITS-1:0] load_value,
  input  logic                    snap,
  input  logic [CH_W-1:0]         rd_sel,
  input  logic                    rd_en,
  output logic [COUNTER_BITS-1:0] rd_data,
  output logic                    rd_valid,
  output logic [NUM_CHANNELS-1:0] ovf,
  input  logic [NUM_CHANNELS-1:0] ovf_clr
);

  if (NUM_CHANNELS == 0 || NUM_CHANNELS > MAX_CHANNELS ||
      COUNTER_BITS == 0 || COUNTER_BITS > MAX_COUNTER_BITS ||
      OFFSET_BITS > MAX_OFFSET_BITS) begin : g_param_check
    $error("sync_counter_array: parameter out of range");
  end

  logic [COUNTER_BITS-1:0] snap_values [NUM_CHANNELS];
  logic [COUNTER_BITS-1:0] rd_mux;

  // Out-of-range load_sel matches no channel, so the load is dropped.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    sync_counter_channel #(
      .COUNTER_BITS(COUNTER_BITS),
      .OFFSET_BITS (OFFSET_BITS)
    ) u_channel (
      .tclk      (tclk),
      .rst       (rst),
      .enable    (enable[i]),
      .clear     (clear[i]),
      .load      (load && (load_sel == CH_W'(i))),
      .load_value(load_value),
      .snap      (snap),
      .ovf_clr   (ovf_clr[i]),
      .snap_value(snap_values[i]),
      .ovf       (ovf[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_sel == CH_W'(i))
        rd_mux = snap_values[i];
    end
  end

  always_ff @(posedge tclk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sync_counter_array.sv
// Self-checking bench: three array configurations against a behavioural count model.
module tb_sync_counter_array;

  logic tclk = 1'b0;
  logic rst;
  always #5 tclk = ~tclk;

  // Index 0: defaults, 1: OFFSET_BITS=4, 2: three 8-bit channels.
  int unsigned P_N  [3] = '{2, 2, 3};
  int unsigned P_CB [3] = '{32, 32, 8};
  int unsigned P_OB [3] = '{0, 4, 0};

  logic [2:0]  en      [3];
  logic [2:0]  clr     [3];
  logic [2:0]  ovf_clr [3];
  logic        ld      [3];
  logic [1:0]  ld_sel  [3];
  logic [31:0] ld_val  [3];
  logic        snap    [3];
  logic [1:0]  rd_sel  [3];
  logic        rd_en   [3];

  logic [31:0] rd_data_a, rd_data_b;
  logic [7:0]  rd_data_c;
  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic [1:0]  ovf_a, ovf_b;
  logic [2:0]  ovf_c;

  logic [31:0] obs_rd  [3];
  logic        obs_rv  [3];
  logic [2:0]  obs_ovf [3];

  always_comb begin
    obs_rd[0]  = rd_data_a;
    obs_rd[1]  = rd_data_b;
    obs_rd[2]  = {24'h0, rd_data_c};
    obs_rv[0]  = rd_valid_a;
    obs_rv[1]  = rd_valid_b;
    obs_rv[2]  = rd_valid_c;
    obs_ovf[0] = {1'b0, ovf_a};
    obs_ovf[1] = {1'b0, ovf_b};
    obs_ovf[2] = ovf_c;
  end

  sync_counter_array u_dut_a (
    .tclk(tclk), .rst(rst), .enable(en[0][1:0]), .clear(clr[0][1:0]),
    .load(ld[0]), .load_sel(ld_sel[0][0:0]), .load_value(ld_val[0]),
    .snap(snap[0]), .rd_sel(rd_sel[0][0:0]), .rd_en(rd_en[0]),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .ovf(ovf_a), .ovf_clr(ovf_clr[0][1:0])
  );

  sync_counter_array #(.NUM_CHANNELS(2), .COUNTER_BITS(32), .OFFSET_BITS(4)) u_dut_b (
    .tclk(tclk), .rst(rst), .enable(en[1][1:0]), .clear(clr[1][1:0]),
    .load(ld[1]), .load_sel(ld_sel[1][0:0]), .load_value(ld_val[1]),
    .snap(snap[1]), .rd_sel(rd_sel[1][0:0]), .rd_en(rd_en[1]),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .ovf(ovf_b), .ovf_clr(ovf_clr[1][1:0])
  );

  sync_counter_array #(.NUM_CHANNELS(3), .COUNTER_BITS(8), .OFFSET_BITS(0)) u_dut_c (
    .tclk(tclk), .rst(rst), .enable(en[2]), .clear(clr[2]),
    .load(ld[2]), .load_sel(ld_sel[2]), .load_value(ld_val[2][7:0]),
    .snap(snap[2]), .rd_sel(rd_sel[2]), .rd_en(rd_en[2]),
    .rd_data(rd_data_c), .rd_valid(rd_valid_c), .ovf(ovf_c), .ovf_clr(ovf_clr[2])
  );

  // Behavioural model: counts as plain integers modulo 2**(CB+OB).
  longint unsigned m_cnt  [3][3];
  longint unsigned m_snap [3][3];
  logic            m_ovf  [3][3];
  logic [31:0]     m_rd   [3];
  logic            m_rv   [3];
  longint unsigned m_top;
  longint unsigned m_mask;
  logic            m_hit_top;

  always @(posedge tclk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        m_rd[d] = '0;
        m_rv[d] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          m_cnt[d][c]  = 0;
          m_snap[d][c] = 0;
          m_ovf[d][c]  = 1'b0;
        end
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_top  = (64'd1 << (P_CB[d] + P_OB[d])) - 64'd1;
        m_mask = (64'd1 << P_CB[d]) - 64'd1;
        m_rv[d] = rd_en[d];
        if (rd_en[d])
          m_rd[d] = (rd_sel[d] < P_N[d]) ? 32'(m_snap[d][rd_sel[d]] >> P_OB[d]) : 32'h0;
        for (int c = 0; c < int'(P_N[d]); c++) begin
          m_hit_top = 1'b0;
          if (snap[d])
            m_snap[d][c] = m_cnt[d][c];
          if (clr[d][c])
            m_cnt[d][c] = 0;
          else if (ld[d] && ld_sel[d] == c)
            m_cnt[d][c] = (64'(ld_val[d]) & m_mask) * (64'd1 << P_OB[d]);
          else if (en[d][c]) begin
            if (m_cnt[d][c] == m_top) begin
              m_hit_top = 1'b1;
`ifdef SYNC_COUNTER_SATURATE_EN
              m_cnt[d][c] = m_top;
`else
              m_cnt[d][c] = 0;
`endif
            end else
              m_cnt[d][c] = m_cnt[d][c] + 1;
          end
          if (m_hit_top)
            m_ovf[d][c] = 1'b1;
          else if (ovf_clr[d][c])
            m_ovf[d][c] = 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      en[d] = '0; clr[d] = '0; ovf_clr[d] = '0; ld[d] = 1'b0; ld_sel[d] = '0;
      ld_val[d] = '0; snap[d] = 1'b0; rd_sel[d] = '0; rd_en[d] = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge tclk);
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    cyc(2);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (obs_rd[d] !== 32'h0 || obs_rv[d] !== 1'b0 || obs_ovf[d] !== 3'b000) begin
        n_errors++;
        $display("FAIL reset dut%0d: got rd_data=%0h rd_valid=%b ovf=%b required 0/0/0",
                 d, obs_rd[d], obs_rv[d], obs_ovf[d]);
      end
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_basic_count();
    en[0] = 3'b001;
    cyc(100);
    en[0] = '0; snap[0] = 1'b1;
    cyc(1);
    snap[0] = 1'b0; rd_sel[0] = 2'd0; rd_en[0] = 1'b1;
    n_checks++;
    if (obs_rv[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_valid_before: got %b required 0", obs_rv[0]);
    end
    cyc(1);
    n_checks++;
    if (obs_rd[0] !== 32'd100 || obs_rv[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_ch0: got %0d valid %b required 100 valid 1", obs_rd[0], obs_rv[0]);
    end
    rd_sel[0] = 2'd1;
    cyc(1);
    n_checks++;
    if (obs_rd[0] !== 32'd0 || obs_rv[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_ch1: got %0d valid %b required 0 valid 1", obs_rd[0], obs_rv[0]);
    end
    rd_en[0] = 1'b0; rd_sel[0] = 2'd0;
    cyc(1);
    n_checks++;
    if (obs_rd[0] !== 32'd0 || obs_rv[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_hold: got %0d valid %b required 0 valid 0", obs_rd[0], obs_rv[0]);
    end
  endtask

  task automatic test_prescale();
    en[1] = 3'b001;
    cyc(35);
    en[1] = '0; snap[1] = 1'b1;
    cyc(1);
    snap[1] = 1'b0; rd_sel[1] = 2'd0; rd_en[1] = 1'b1;
    cyc(1);
    rd_en[1] = 1'b0;
    n_checks++;
    if (obs_rd[1] !== 32'd2 || obs_rv[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL prescale_35: got %0d valid %b required 2 valid 1", obs_rd[1], obs_rv[1]);
    end
    ld[1] = 1'b1; ld_sel[1] = 2'd0; ld_val[1] = 32'd7;
    cyc(1);
    ld[1] = 1'b0; en[1] = 3'b001;
    cyc(16);
    en[1] = '0; snap[1] = 1'b1;
    cyc(1);
    snap[1] = 1'b0; rd_en[1] = 1'b1;
    cyc(1);
    rd_en[1] = 1'b0;
    n_checks++;
    if (obs_rd[1] !== 32'd8) begin
      n_errors++;
      $display("FAIL prescale_load: got %0d required 8", obs_rd[1]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_rd;
`ifdef SYNC_COUNTER_SATURATE_EN
    exp_rd = 32'hFF;
`else
    exp_rd = 32'h01;
`endif
    ld[2] = 1'b1; ld_sel[2] = 2'd0; ld_val[2] = 32'hFE;
    cyc(1);
    ld[2] = 1'b0; en[2] = 3'b001;
    cyc(3);
    en[2] = '0; snap[2] = 1'b1;
    cyc(1);
    snap[2] = 1'b0; rd_sel[2] = 2'd0; rd_en[2] = 1'b1;
    cyc(1);
    rd_en[2] = 1'b0;
    n_checks++;
    if (obs_rd[2] !== exp_rd || obs_ovf[2] !== 3'b001) begin
      n_errors++;
      $display("FAIL overflow_fe: got %0h ovf %b required %0h ovf 001", obs_rd[2], obs_ovf[2], exp_rd);
    end
    ovf_clr[2] = 3'b001;
    cyc(1);
    ovf_clr[2] = '0;
    n_checks++;
    if (obs_ovf[2] !== 3'b000) begin
      n_errors++;
      $display("FAIL ovf_clr: got %b required 000", obs_ovf[2]);
    end
    ld[2] = 1'b1; ld_val[2] = 32'hFF;
    cyc(1);
    ld[2] = 1'b0; en[2] = 3'b001; ovf_clr[2] = 3'b001;
    cyc(1);
    en[2] = '0; ovf_clr[2] = '0;
    n_checks++;
    if (obs_ovf[2] !== 3'b001) begin
      n_errors++;
      $display("FAIL ovf_clr_vs_new: got %b required 001", obs_ovf[2]);
    end
  endtask

  task automatic test_same_cycle();
    en[0] = 3'b010;
    cyc(5);
    clr[0] = 3'b010; ld[0] = 1'b1; ld_sel[0] = 2'd1; ld_val[0] = 32'd123; snap[0] = 1'b1;
    cyc(1);
    idle_all();
    rd_sel[0] = 2'd1; rd_en[0] = 1'b1;
    cyc(1);
    n_checks++;
    if (obs_rd[0] !== 32'd5) begin
      n_errors++;
      $display("FAIL same_cycle_snap: got %0d required 5", obs_rd[0]);
    end
    snap[0] = 1'b1;
    cyc(1);
    snap[0] = 1'b0;
    n_checks++;
    if (obs_rd[0] !== 32'd5 || obs_rv[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL snap_read_old: got %0d valid %b required 5 valid 1", obs_rd[0], obs_rv[0]);
    end
    cyc(1);
    n_checks++;
    if (obs_rd[0] !== 32'd0) begin
      n_errors++;
      $display("FAIL same_cycle_cleared: got %0d required 0", obs_rd[0]);
    end
    rd_sel[0] = 2'd0;
    cyc(1);
    rd_en[0] = 1'b0;
    n_checks++;
    if (obs_rd[0] !== 32'd100) begin
      n_errors++;
      $display("FAIL same_cycle_ch0: got %0d required 100", obs_rd[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] exp_ch0;
    en[2] = 3'b110;
    cyc(4);
    en[2] = '0; rd_sel[2] = 2'd3; rd_en[2] = 1'b1;
    cyc(1);
    rd_en[2] = 1'b0;
    n_checks++;
    if (obs_rd[2] !== 32'h0 || obs_rv[2] !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_sel_oor: got %0h valid %b required 0 valid 1", obs_rd[2], obs_rv[2]);
    end
`ifdef SYNC_COUNTER_SATURATE_EN
    exp_ch0 = 32'hFF;
`else
    exp_ch0 = 32'h00;
`endif
    ld[2] = 1'b1; ld_sel[2] = 2'd3; ld_val[2] = 32'd55;
    cyc(1);
    ld[2] = 1'b0; snap[2] = 1'b1;
    cyc(1);
    snap[2] = 1'b0; rd_en[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rd_sel[2] = 2'(c);
      cyc(1);
      n_checks++;
      if (obs_rd[2] !== ((c == 0) ? exp_ch0 : 32'd4)) begin
        n_errors++;
        $display("FAIL load_sel_oor ch%0d: got %0h required %0h", c, obs_rd[2],
                 (c == 0) ? exp_ch0 : 32'd4);
      end
    end
    rd_en[2] = 1'b0;
  endtask

  task automatic test_async_reset();
    idle_all();
    en[0] = 3'b011;
    cyc(7);
    en[0] = '0; snap[0] = 1'b1;
    cyc(1);
    snap[0] = 1'b0; rd_sel[0] = 2'd1; rd_en[0] = 1'b1; en[0] = 3'b011;
    cyc(1);
    rd_en[0] = 1'b0;
    n_checks++;
    if (obs_rd[0] !== 32'd7) begin
      n_errors++;
      $display("FAIL pre_reset_ch1: got %0d required 7", obs_rd[0]);
    end
    cyc(2);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (obs_rd[d] !== 32'h0 || obs_rv[d] !== 1'b0 || obs_ovf[d] !== 3'b000) begin
        n_errors++;
        $display("FAIL async_reset dut%0d: got rd_data=%0h rd_valid=%b ovf=%b required 0/0/0",
                 d, obs_rd[d], obs_rv[d], obs_ovf[d]);
      end
    end
    @(negedge tclk);
    rst = 1'b0;
    cyc(3);
    en[0] = '0; snap[0] = 1'b1;
    cyc(1);
    snap[0] = 1'b0; rd_sel[0] = 2'd0; rd_en[0] = 1'b1;
    cyc(1);
    rd_en[0] = 1'b0;
    n_checks++;
    if (obs_rd[0] !== 32'd3) begin
      n_errors++;
      $display("FAIL post_reset_count: got %0d required 3", obs_rd[0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] mask;
    logic [2:0]  exp_ovf;
    for (int cycle = 0; cycle < 400; cycle++) begin
      for (int d = 0; d < 3; d++) begin
        mask = (P_CB[d] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        en[d]      = 3'($urandom_range(0, 7));
        clr[d]     = 3'($urandom_range(0, 15) == 0 ? $urandom_range(1, 7) : 0);
        ovf_clr[d] = 3'($urandom_range(0, 7) == 0 ? $urandom_range(1, 7) : 0);
        ld[d]      = ($urandom_range(0, 7) == 0);
        ld_sel[d]  = 2'($urandom_range(0, (P_N[d] == 3) ? 3 : 1));
        ld_val[d]  = $urandom_range(0, 1) ? (mask - 32'($urandom_range(0, 3))) : ($urandom & mask);
        snap[d]    = ($urandom_range(0, 3) == 0);
        rd_en[d]   = ($urandom_range(0, 1) == 0);
        rd_sel[d]  = 2'($urandom_range(0, (P_N[d] == 3) ? 3 : 1));
      end
      cyc(1);
      for (int d = 0; d < 3; d++) begin
        exp_ovf = '0;
        for (int c = 0; c < int'(P_N[d]); c++)
          exp_ovf[c] = m_ovf[d][c];
        n_checks++;
        if (obs_rv[d] !== m_rv[d] || (m_rv[d] && obs_rd[d] !== m_rd[d])) begin
          n_errors++;
          $display("FAIL random_read dut%0d cycle %0d: got %0h valid %b required %0h valid %b",
                   d, cycle, obs_rd[d], obs_rv[d], m_rd[d], m_rv[d]);
        end
        n_checks++;
        if (obs_ovf[d] !== exp_ovf) begin
          n_errors++;
          $display("FAIL random_ovf dut%0d cycle %0d: got %b required %b",
                   d, cycle, obs_ovf[d], exp_ovf);
        end
      end
    end
    idle_all();
    cyc(1);
  endtask

  initial begin
    idle_all();
    rst = 1'b0;
    #1;
    test_reset();
    test_basic_count();
    test_prescale();
    test_overflow();
    test_same_cycle();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_counter_array.md
Name: sync_counter_array

Overview:
- N-channel generalisation of the two-channel A/B sync counter core, all channels in the tclk domain.
- Each channel counts tclk cycles while its enable is high, with a per-channel prescale by dropped LSBs (OFFSET_BITS).
- Adds per-channel clear, preload, simultaneous snapshot of all channels, a registered read mux, and sticky overflow flags.
- Sits under the AXI interface wrapper, which drives the strobes and reads results.

Parameters:
- NUM_CHANNELS, 2, number of independent counters (1..32).
- COUNTER_BITS, 32, width of reported count, load value and rd_data (1..32).
- OFFSET_BITS, 0, extra low-order prescale bits; internal counter width W = COUNTER_BITS+OFFSET_BITS (0..16).
- CH_W, $clog2(NUM_CHANNELS) min 1, channel-select width (derived, not overridden).

Ports:
- tclk  in  1  counter clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  NUM_CHANNELS  per-channel count enable, level.
- clear  in  NUM_CHANNELS  per-channel synchronous clear strobe.
- load  in  1  preload strobe for channel load_sel.
- load_sel  in  CH_W  channel to preload.
- load_value  in  COUNTER_BITS  preload value, placed in the upper COUNTER_BITS; low OFFSET_BITS zeroed.
- snap  in  1  snapshot strobe; latches all channels simultaneously.
- rd_sel  in  CH_W  snapshot channel to read.
- rd_en  in  1  read request.
- rd_data  out  COUNTER_BITS  snapshot[rd_sel] >> OFFSET_BITS, registered.
- rd_valid  out  1  one-cycle pulse with rd_data.
- ovf  out  NUM_CHANNELS  sticky overflow flags.
- ovf_clr  in  NUM_CHANNELS  per-channel overflow clear strobe.

Behaviour:
- Reset (async assert, sync release): all counters, snapshots, rd_data, rd_valid and ovf are 0.
- Counting: cnt[i] <= cnt[i]+1 each tclk edge with enable[i]=1, modulo 2^W. The reported value is cnt[i][W-1:OFFSET_BITS].
- Per-channel priority, highest first: clear > load (load_sel==i) > increment. With OFFSET_BITS=0, load sets cnt to load_value.
- Overflow: an increment from all-ones sets ovf[i] the same edge. Counter wraps to 0 (default).
- ovf_clr[i] clears ovf[i]. A simultaneous new overflow wins; flag stays 1.
- Snapshot: on snap, snap_reg[i] <= cnt[i] for every i, capturing the pre-edge value. Same-cycle clear, load or increment does not affect the captured value.
- Snapshot registers hold until the next snap or reset.
- Read: rd_en at edge k gives rd_data = snap_reg[rd_sel]>>OFFSET_BITS and rd_valid=1 after edge k, i.e. one-cycle latency.
  - If snap and rd_en coincide, rd_data returns the old snapshot.
  - rd_data holds its last value when rd_en=0; rd_valid=0.
  - rd_sel >= NUM_CHANNELS returns 0 with rd_valid=1.
- Back-to-back rd_en every cycle is supported, full throughput.
- load_sel >= NUM_CHANNELS: load ignored.
- Reset mid-count: immediate 0 on all state; the first count after deassertion is at the first edge with enable high.
- No FSM; per-channel datapath plus read register.

Optional Feature:
- Macro SYNC_COUNTER_SATURATE_EN.
- Defined: counter at all-ones with enable holds at all-ones (no wrap) and ovf[i] is set. Load and clear still operate.
- Undefined: wrap to 0 as above.

Decomposition:
- Package sync_counter_pkg holds the clog2-min-1 function for CH_W, the OFFSET_BITS/COUNTER_BITS range limits, and localparam W derivation.
- Sub-module sync_counter_channel: one counter with clear/load/increment priority, overflow flag and snapshot register, instantiated NUM_CHANNELS times via generate.
- Read mux and rd_valid live in the top.

Test Plan:
- Defaults, enable=2'b01 for 100 cycles, snap, rd_sel=0 then 1 -> rd_data=100 then 0, each rd_valid one cycle after rd_en.
- OFFSET_BITS=4, enable ch0 for 35 cycles, snap, read -> rd_data=2. Load 7 then 16 cycles, snap, read -> 8.
- COUNTER_BITS=8, load 8'hFE, enable 3 cycles, snap, read -> rd_data=1, ovf[0]=1. With SYNC_COUNTER_SATURATE_EN -> rd_data=8'hFF, ovf[0]=1.
- clear, load and enable on ch1 in the same cycle with snap -> snapshot holds the pre-edge count, counter=0 after the edge. ovf_clr together with a new overflow -> ovf stays 1.
- Assert rst asynchronously mid-count, between edges -> all outputs 0 immediately. After release with enable held, the first increment is on the next edge.
- NUM_CHANNELS=3, rd_sel=3 -> rd_data=0, rd_valid=1. load_sel=3 -> no channel changes.
